// File: rtl/max_scan_engine.sv
// Scan engine: walks a word array in data memory, finds the signed maximum and its
// offset, then writes them to MAX_ADDR and IDX_ADDR while holding the memory port.
module max_scan_engine #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 16,
  parameter int MAX_ADDR = 200,
  parameter int IDX_ADDR = 204
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] count,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy,
  output logic              done,
  output logic              empty,
  output logic [DATA_W-1:0] result_max,
  output logic [DATA_W-1:0] result_index
);

  typedef enum logic [2:0] {IDLE, FIRST, SCAN, WR_MAX, WR_IDX, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic [ADDR_W-1:0]   i_q, i_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   max_q, max_d;
  logic [DATA_W-1:0]   result_max_q, result_max_d;
  logic [DATA_W-1:0]   result_index_q, result_index_d;
  logic                empty_q, empty_d;

  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    count_d        = count_q;
    i_d            = i_q;
    idx_d          = idx_q;
    max_d          = max_q;
    result_max_d   = result_max_q;
    result_index_d = result_index_q;
    empty_d        = empty_q;
    mem_address    = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_write_data = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            base_d  = base_addr;
            count_d = count;
            i_d     = '0;
            empty_d = 1'b0;
            state_d = FIRST;
          end else begin
            empty_d = 1'b1;
            state_d = DONE;
          end
        end
      end
      FIRST: begin
        mem_address = base_q;
        mem_read    = 1'b1;
        max_d       = mem_read_data;
        idx_d       = '0;
        i_d         = ADDR_W'(1);
        state_d     = (count_q > ADDR_W'(1)) ? SCAN : WR_MAX;
      end
      SCAN: begin
        // Address wraps naturally at ADDR_W bits; strict compare keeps the earliest tie.
        mem_address = base_q + i_q;
        mem_read    = 1'b1;
        if ($signed(mem_read_data) > $signed(max_q)) begin
          max_d = mem_read_data;
          idx_d = i_q;
        end
        i_d = i_q + ADDR_W'(1);
        if (i_q == count_q - ADDR_W'(1)) state_d = WR_MAX;
      end
      WR_MAX: begin
        mem_address    = ADDR_W'(MAX_ADDR);
        mem_write      = 1'b1;
        mem_write_data = max_q;
        state_d        = WR_IDX;
      end
      WR_IDX: begin
        mem_address    = ADDR_W'(IDX_ADDR);
        mem_write      = 1'b1;
        mem_write_data = DATA_W'(idx_q);
        result_max_d   = max_q;
        result_index_d = DATA_W'(idx_q);
        state_d        = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      base_q         <= '0;
      count_q        <= '0;
      i_q            <= '0;
      idx_q          <= '0;
      max_q          <= '0;
      result_max_q   <= '0;
      result_index_q <= '0;
      empty_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      base_q         <= base_d;
      count_q        <= count_d;
      i_q            <= i_d;
      idx_q          <= idx_d;
      max_q          <= max_d;
      result_max_q   <= result_max_d;
      result_index_q <= result_index_d;
      empty_q        <= empty_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign empty        = done & empty_q;
  assign result_max   = result_max_q;
  assign result_index = result_index_q;

endmodule

// File: tb/tb_max_scan_engine.sv
// Directed bench for max_scan_engine with a 4096x16 behavioural memory.
module tb_max_scan_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] base_addr;
  logic [11:0] count;
  logic [11:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_write_data;
  logic [15:0] mem_read_data;
  logic        busy;
  logic        done;
  logic        empty;
  logic [15:0] result_max;
  logic [15:0] result_index;

  logic [15:0] mem [4096];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] base;
    int          n;
    logic [15:0] d [10];
    logic [15:0] emax;
    logic [15:0] eidx;
  } vec_t;

  vec_t vecs [7];

  max_scan_engine #(.ADDR_W(12), .DATA_W(16), .MAX_ADDR(200), .IDX_ADDR(204)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .busy(busy), .done(done), .empty(empty),
    .result_max(result_max), .result_index(result_index)
  );

  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_address];
  always @(posedge clk) if (mem_write) mem[mem_address] <= mem_write_data;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endfunction

  task automatic run(input int r, input bit poke);
    logic [11:0] b, ea;
    logic [15:0] ewd;
    int n, dc;
    bit got, er, ew;
    b = vecs[r].base;
    n = vecs[r].n;
    for (int j = 0; j < n; j++) mem[b + 12'(j)] = vecs[r].d[j];
    mem[200] = 16'hDEAD;
    mem[204] = 16'hBEEF;
    base_addr = b;
    count     = 12'(n);
    start     = 1'b1;
    dc  = (n == 0) ? 1 : n + 3;
    got = 1'b0;
    for (int c = 1; c <= n + 10 && !got; c++) begin
      @(negedge clk);
      start = poke && (c <= 3);
      er  = (n > 0) && (c <= n);
      ew  = (n > 0) && (c == n + 1 || c == n + 2);
      ea  = er ? b + 12'(c - 1) : (ew && c == n + 1) ? 12'd200 : ew ? 12'd204 : 12'd0;
      ewd = !ew ? 16'h0 : (c == n + 1) ? vecs[r].emax : vecs[r].eidx;
      chk($sformatf("r%0d c%0d busy", r, c), 32'(busy), 32'd1);
      chk($sformatf("r%0d c%0d mem_read", r, c), 32'(mem_read), 32'(er));
      chk($sformatf("r%0d c%0d mem_write", r, c), 32'(mem_write), 32'(ew));
      chk($sformatf("r%0d c%0d mem_address", r, c), 32'(mem_address), 32'(ea));
      chk($sformatf("r%0d c%0d wdata", r, c), 32'(mem_write_data), 32'(ewd));
      chk($sformatf("r%0d c%0d done", r, c), 32'(done), 32'(c == dc));
      if (done) begin
        got = 1'b1;
        chk($sformatf("r%0d empty", r), 32'(empty), 32'(n == 0));
        if (n > 0) begin
          chk($sformatf("r%0d result_max", r), 32'(result_max), 32'(vecs[r].emax));
          chk($sformatf("r%0d result_index", r), 32'(result_index), 32'(vecs[r].eidx));
        end
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL r%0d done_timeout actual=none required=cycle%0d", r, dc);
    end
    @(negedge clk);
    chk($sformatf("r%0d idle busy", r), 32'(busy), 32'd0);
    chk($sformatf("r%0d idle done", r), 32'(done), 32'd0);
    chk($sformatf("r%0d word200", r), 32'(mem[200]), 32'((n > 0) ? vecs[r].emax : 16'hDEAD));
    chk($sformatf("r%0d word204", r), 32'(mem[204]), 32'((n > 0) ? vecs[r].eidx : 16'hBEEF));
  endtask

  initial begin
    vecs[0] = '{12'd1000, 10, '{16'd3, 16'd7, 16'hFFFE, 16'd7, 16'd15, 16'd0, 16'd15, 16'd1, 16'd9, 16'd4}, 16'd15, 16'd4};
    vecs[1] = '{12'd500, 4, '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 0, 0, 0, 0, 0, 0}, 16'h8000, 16'd0};
    vecs[2] = '{12'd600, 2, '{16'h7FFF, 16'hFFFF, 0, 0, 0, 0, 0, 0, 0, 0}, 16'h7FFF, 16'd0};
    vecs[3] = '{12'd700, 0, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 16'd0, 16'd0};
    vecs[4] = '{12'd4094, 4, '{16'd1, 16'd2, 16'd9, 16'd3, 0, 0, 0, 0, 0, 0}, 16'd9, 16'd2};
    vecs[5] = '{12'd300, 1, '{16'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 16'h1234, 16'd0};
    vecs[6] = '{12'd10, 3, '{16'hFFFB, 16'hFFFD, 16'hFFFF, 0, 0, 0, 0, 0, 0, 0}, 16'hFFFF, 16'd2};

    for (int a = 0; a < 4096; a++) mem[a] = 16'h0;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; count = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset empty", 32'(empty), 32'd0);
    chk("reset mem_read", 32'(mem_read), 32'd0);
    chk("reset mem_write", 32'(mem_write), 32'd0);
    chk("reset mem_address", 32'(mem_address), 32'd0);
    chk("reset result_max", 32'(result_max), 32'd0);
    chk("reset result_index", 32'(result_index), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 7; r++) run(r, 1'b0);
    // start held high in cycles 1..3 of a running scan must not restart it
    run(1, 1'b1);

    // reset at the edge ending cycle 5 of an N=10 scan
    for (int j = 0; j < 10; j++) mem[12'd1000 + 12'(j)] = vecs[0].d[j];
    mem[200] = 16'hDEAD; mem[204] = 16'hBEEF;
    base_addr = 12'd1000; count = 12'd10; start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort mem_read", 32'(mem_read), 32'd0);
    chk("abort mem_write", 32'(mem_write), 32'd0);
    chk("abort result_max", 32'(result_max), 32'd0);
    chk("abort result_index", 32'(result_index), 32'd0);
    repeat (12) @(negedge clk);
    chk("abort busy later", 32'(busy), 32'd0);
    chk("abort word200", 32'(mem[200]), 32'hDEAD);
    chk("abort word204", 32'(mem[204]), 32'hBEEF);

    // reset during WR_MAX: the max write commits, the index write never happens
    mem[300] = 16'h1234; mem[200] = 16'hDEAD; mem[204] = 16'hBEEF;
    base_addr = 12'd300; count = 12'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("wrmax mem_write", 32'(mem_write), 32'd1);
    chk("wrmax mem_address", 32'(mem_address), 32'd200);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("wrmax abort busy", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
    chk("wrmax word200", 32'(mem[200]), 32'h1234);
    chk("wrmax word204", 32'(mem[204]), 32'hBEEF);
    chk("wrmax result_max", 32'(result_max), 32'd0);

    // engine still usable after an aborted run
    run(6, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/max_scan_engine.md
# max_scan_engine

Memory-side scan engine for the multi-cycle processor: on a start pulse it walks a contiguous array of 16-bit words in the 4096×16 data memory, finds the largest signed element and its offset, then writes the maximum to word 200 and the offset to word 204. It is the master on the memory port: it drives the memory's address, read/write strobes and write data, and consumes the memory's combinational read data. It runs while the CPU controller holds off memory access, and `busy` is the arbitration flag.

## Interface
- `ADDR_W`, 12: memory address width (4096 words).
- `DATA_W`, 16: memory word width.
- `MAX_ADDR`, 200: word address receiving the maximum value.
- `IDX_ADDR`, 204: word address receiving the element offset.

One clock; reset is synchronous and active-low.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `base_addr`  in  ADDR_W  word address of element 0; latched on accepted start.
- `count`  in  ADDR_W  number of elements; latched on accepted start.
- `mem_address`  out  ADDR_W  memory address.
- `mem_read`  out  1  memory read strobe.
- `mem_write`  out  1  memory write strobe; the write commits at the rising edge ending the cycle.
- `mem_write_data`  out  DATA_W  memory write data.
- `mem_read_data`  in  DATA_W  memory read data, combinational from `mem_address`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `empty`  out  1  valid with `done`; high when the latched count was 0.
- `result_max`  out  DATA_W  registered maximum; holds until the next accepted start.
- `result_index`  out  DATA_W  registered offset, zero-extended; holds until the next accepted start.

## Operation
- States: IDLE, FIRST, SCAN, WR_MAX, WR_IDX, DONE.
- IDLE
  - If `start`=1 and count≠0, latch base and count, clear offset counter `i`, go to FIRST.
  - If `start`=1 and count=0, go to DONE with `empty`=1. No memory access and no memory write occur.
- FIRST
  - `mem_address`=base, `mem_read`=1.
  - At the edge: max←`mem_read_data`, idx←0, i←1.
  - Go to SCAN if count>1, otherwise go to WR_MAX.
- SCAN
  - `mem_address`=(base+i) mod 4096, `mem_read`=1.
  - If `mem_read_data` > max (signed, strict), update max←data and idx←i.
  - i←i+1. When i=count−1, go to WR_MAX.
- WR_MAX: `mem_address`=MAX_ADDR, `mem_write`=1, `mem_write_data`=max.
- WR_IDX: `mem_address`=IDX_ADDR, `mem_write`=1, `mem_write_data`={4'b0,idx}.
- DONE: `done`=1 for one cycle, then return to IDLE.
- Memory outputs are Moore-decoded from the state and registers only; there is no combinational path from `start`.
- Outside read states `mem_read`=0; outside write states `mem_write`=0. `mem_address` and `mem_write_data` are 0 when unused.
- Comparison is two's complement signed. On ties the lowest offset is kept.
- Address arithmetic is ADDR_W bits and wraps from 4095 to 0.
- `start` asserted while `busy` is ignored and is not queued.
- Array elements overlapping 200/204 are read before either write, because writes occur only after the scan.

## Timing
- Reset (`rst_n`=0 at an edge) forces state IDLE and clears i, max, idx, `result_max`, `result_index`, `done`, `empty` and `busy`. All memory strobes are 0 from the next cycle.
- Reset mid-scan aborts without writing. Reset during WR_MAX leaves word 204 untouched.
- With start sampled at edge E0 and count=N≥1:
  - FIRST occupies cycle 1.
  - SCAN occupies cycles 2..N.
  - WR_MAX occupies cycle N+1.
  - WR_IDX occupies cycle N+2.
  - DONE occupies cycle N+3.
- Total latency is N+3 cycles; `busy` is high for cycles 1..N+3.
- count=0: DONE in cycle 1, `busy` high in cycle 1 only.
- `result_max`/`result_index` update at the edge leaving WR_IDX and are valid while `done`=1.
- A new start is accepted in the first IDLE cycle after DONE.

## Test plan
- base=1000, N=10, data {3,7,−2,7,15,0,15,1,9,4} -> word200=15, word204=4, `done` in cycle 13, `busy` cycles 1–13.
- base=500, N=4, all 0x8000 -> max=0x8000, index=0 (tie keeps first); signed check: {0x7FFF,0xFFFF} gives max 0x7FFF, index 0.
- N=0 -> `done`=`empty`=1 in cycle 1, no `mem_read`/`mem_write` ever high, words 200/204 unchanged.
- base=4094, N=4, words 4094,4095,0,1 = {1,2,9,3} -> addresses 4094,4095,0,1 in sequence, max 9, index 2.
- `rst_n`=0 in cycle 5 of an N=10 scan -> state IDLE next cycle, words 200/204 unchanged, results 0. Start pulses during `busy` -> no restart, latency unchanged.
- N=1, base=300, data 0x1234 -> FIRST, WR_MAX, WR_IDX, DONE in cycles 1–4; word200=0x1234, word204=0.
